uart_word_rx: RTL

Standalone UART receiver that deserializes 8N1 frames from a single `rx` line and assembles `NUM_WORDS` consecutive words into one `W_OUT`-bit beat on a valid/ready master stream. It is the far-end counterpart of the word-packing transmitter in the UART subsystem and consumes its serial output. Unlike the basic receiver, it adds input synchronization, glitch rejection, framing-error detection, output backpressure and overrun reporting.

---
 rtl/uart_word_rx_if.sv | 21 ++
 rtl/uart_word_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_word_rx_if.sv
// Valid/ready stream carrying one assembled beat from the UART word receiver.
// The master drives m_valid/m_data and the slave drives m_ready.
interface uart_word_rx_if #(
    parameter int W_OUT = 16
);
    logic             m_valid;
    logic             m_ready;
    logic [W_OUT-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs NUM_WORDS consecutive words into one W_OUT-bit beat,
// with input synchronization, glitch rejection, framing-error and overrun reporting.
module uart_word_rx #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_word_rx_if.master m_if,
    output logic           frame_err,
    output logic           overrun
);
    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CW        = $clog2(CLOCKS_PER_PULSE);
    localparam int BW        = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CW-1:0] HALF_M1   = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                   state_q;
    logic                     rx_meta_q;
    logic                     rxs_q;
    logic [CW-1:0]            cnt_q;
    logic [BW-1:0]            bit_idx_q;
    logic [WW-1:0]            word_idx_q;
    logic [BITS_PER_WORD-1:0] shift_q;
    logic [W_OUT-1:0]         asm_q;
    logic [W_OUT-1:0]         m_data_q;
    logic                     m_valid_q;
    logic                     frame_err_q;
    logic                     overrun_q;

    logic [W_OUT-1:0]         beat_d;
    logic                     stop_sample_d;
    logic                     beat_done_d;

    // Two-flop synchronizer; reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Assembly register with the just-received word dropped into its slot.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
        assign beat_d[gi*BITS_PER_WORD +: BITS_PER_WORD] =
            (word_idx_q == WW'(gi)) ? shift_q : asm_q[gi*BITS_PER_WORD +: BITS_PER_WORD];
    end

    always_comb begin
        stop_sample_d = (state_q == S_STOP) && (cnt_q == FULL_M1);
        beat_done_d   = stop_sample_d && rxs_q && (word_idx_q == LAST_WORD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            word_idx_q  <= '0;
            shift_q     <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (m_valid_q && m_if.m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        cnt_q   <= '0;
                        state_q <= S_START;
                    end
                end

                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        if (!rxs_q) begin
                            bit_idx_q <= '0;
                            state_q   <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[BITS_PER_WORD-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (stop_sample_d) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            asm_q   <= beat_d;
                            state_q <= S_IDLE;
                            if (word_idx_q == LAST_WORD) begin
                                word_idx_q <= '0;
                            end else begin
                                word_idx_q <= word_idx_q + WW'(1);
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            word_idx_q  <= '0;
                            state_q     <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_WAIT_IDLE: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase

            // A slot frees up in the same cycle the current beat is accepted.
            if (beat_done_d) begin
                if (!m_valid_q || m_if.m_ready) begin
                    m_data_q  <= beat_d;
                    m_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = m_data_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
endmodule
